// File: rtl/exception_ctrl_if.sv
// Decoder/core <-> exception controller bundle: cause, return, PC and MRS select in;
// redirect, acknowledge, status and system-register read data out.
interface exception_ctrl_if;
  logic [3:0]  EStatus;
  logic        ERet;
  logic        ExtIRQ;
  logic [63:0] PC;
  logic [1:0]  SysRegSel;
  logic        Exc;
  logic [63:0] ExcVector;
  logic [63:0] ERetPC;
  logic        ExtIAck;
  logic        InHandler;
  logic        Halt;
  logic [63:0] SysRegData;

  modport master (
    output EStatus, ERet, ExtIRQ, PC, SysRegSel,
    input  Exc, ExcVector, ERetPC, ExtIAck, InHandler, Halt, SysRegData
  );

  modport slave (
    input  EStatus, ERet, ExtIRQ, PC, SysRegSel,
    output Exc, ExcVector, ERetPC, ExtIAck, InHandler, Halt, SysRegData
  );
endinterface

// File: rtl/exception_ctrl.sv
// Exception/interrupt controller: captures faulting PC and cause, redirects fetch to the vector,
// masks IRQs inside the handler and halts on a fault taken while already in the handler.
module exception_ctrl #(
  parameter logic [63:0] VEC_BASE = 64'h0000_0000_0000_00D8,
  parameter int          COUNT_W  = 16
) (
  input  logic           clk,
  input  logic           reset,
  exception_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    TAKE    = 2'b01,
    HANDLER = 2'b10,
    HALT    = 2'b11
  } state_t;

  state_t               state_r;
  state_t               state_s;
  logic                 capture_s;
  logic [63:0]          elr_r;
  logic [3:0]           esr_r;
  logic [COUNT_W-1:0]   exc_count_r;
  logic [63:0]          sys_reg_data_s;

  // State register; synchronous active-low reset has priority over every transition.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Exception registers load PC/cause and bump the counter only on a capture.
  always_ff @(posedge clk) begin
    if (!reset) begin
      elr_r       <= 64'h0;
      esr_r       <= 4'h0;
      exc_count_r <= '0;
    end else if (capture_s) begin
      elr_r       <= bus.PC;
      esr_r       <= bus.EStatus;
      exc_count_r <= exc_count_r + {{(COUNT_W-1){1'b0}}, 1'b1};
    end else begin
      elr_r       <= elr_r;
      esr_r       <= esr_r;
      exc_count_r <= exc_count_r;
    end
  end

  // Next-state and capture decode; ERet outranks a new cause inside the handler.
  always_comb begin
    state_s   = state_r;
    capture_s = 1'b0;
    case (state_r)
      IDLE: begin
        if (bus.EStatus != 4'b0000) begin
          capture_s = 1'b1;
          state_s   = TAKE;
        end else begin
          state_s   = IDLE;
        end
      end
      TAKE: begin
        state_s = HANDLER;
      end
      HANDLER: begin
        if (bus.ERet) begin
          state_s = IDLE;
        end else if (bus.EStatus == 4'b0001) begin
          // Nested IRQ stays pending at the source until the handler returns.
          state_s = HANDLER;
        end else if (bus.EStatus != 4'b0000) begin
          capture_s = 1'b1;
          state_s   = HALT;
        end else begin
          state_s = HANDLER;
        end
      end
      HALT: begin
        state_s = HALT;
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // MRS read mux, zero-extended to 64 bits.
  always_comb begin
    sys_reg_data_s = 64'h0;
    case (bus.SysRegSel)
      2'b00:   sys_reg_data_s = elr_r;
      2'b01:   sys_reg_data_s = {60'h0, esr_r};
      2'b10:   sys_reg_data_s = {{(64-COUNT_W){1'b0}}, exc_count_r};
      2'b11:   sys_reg_data_s = {62'h0, state_r};
      default: sys_reg_data_s = 64'h0;
    endcase
  end

  assign bus.Exc        = (state_r == TAKE);
  assign bus.ExtIAck    = (state_r == TAKE) && (esr_r == 4'b0001);
  assign bus.InHandler  = (state_r == HANDLER);
  assign bus.Halt       = (state_r == HALT);
  assign bus.ExcVector  = VEC_BASE;
  assign bus.ERetPC     = elr_r;
  assign bus.SysRegData = sys_reg_data_s;

endmodule

// File: tb/tb_exception_ctrl.sv
// Directed self-checking bench for exception_ctrl; a second instance with a narrow
// counter exercises the ExcCount wrap within a short run.
module tb_exception_ctrl;
  logic clk = 1'b0;
  logic reset;
  int   tests = 0;
  int   fails = 0;

  always #10 clk = ~clk;

  exception_ctrl_if bus ();
  exception_ctrl_if bus_w ();

  exception_ctrl dut (.clk(clk), .reset(reset), .bus(bus));
  exception_ctrl #(.COUNT_W(4)) dut_w (.clk(clk), .reset(reset), .bus(bus_w));

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic rd(input string tag, input logic [1:0] sel, input logic [63:0] exp);
    bus.SysRegSel = sel;
    #1;
    chk(tag, bus.SysRegData, exp);
  endtask

  task automatic rd_w(input string tag, input logic [1:0] sel, input logic [63:0] exp);
    bus_w.SysRegSel = sel;
    #1;
    chk(tag, bus_w.SysRegData, exp);
  endtask

  initial begin
    reset = 1'b0;
    bus.EStatus = 4'b0010; bus.ERet = 1'b0; bus.ExtIRQ = 1'b0;
    bus.PC = 64'h300; bus.SysRegSel = 2'b00;
    bus_w.EStatus = 4'b0000; bus_w.ERet = 1'b0; bus_w.ExtIRQ = 1'b0;
    bus_w.PC = 64'h0; bus_w.SysRegSel = 2'b10;

    // Reset held two cycles with a pending cause
    tick(); tick();
    chk("rst_exc", {63'h0, bus.Exc}, 64'h0);
    chk("rst_ack", {63'h0, bus.ExtIAck}, 64'h0);
    chk("rst_inh", {63'h0, bus.InHandler}, 64'h0);
    chk("rst_halt", {63'h0, bus.Halt}, 64'h0);
    chk("rst_eretpc", bus.ERetPC, 64'h0);
    chk("rst_vec", bus.ExcVector, 64'h0000_0000_0000_00D8);
    rd("rst_cnt", 2'b10, 64'h0);
    rd("rst_state", 2'b11, 64'h0);
    bus.EStatus = 4'b0000;
    reset = 1'b1;
    tick();
    chk("idle_inh", {63'h0, bus.InHandler}, 64'h0);

    // Invalid opcode
    bus.PC = 64'h100; bus.EStatus = 4'b0010;
    tick();
    bus.EStatus = 4'b0000;
    chk("inv_exc", {63'h0, bus.Exc}, 64'h1);
    chk("inv_ack", {63'h0, bus.ExtIAck}, 64'h0);
    chk("inv_inh_take", {63'h0, bus.InHandler}, 64'h0);
    rd("inv_state_take", 2'b11, 64'h1);
    tick();
    chk("inv_exc_off", {63'h0, bus.Exc}, 64'h0);
    chk("inv_inh", {63'h0, bus.InHandler}, 64'h1);
    rd("inv_elr", 2'b00, 64'h100);
    rd("inv_esr", 2'b01, 64'h2);
    rd("inv_cnt", 2'b10, 64'h1);
    bus.ERet = 1'b1;
    tick();
    bus.ERet = 1'b0;
    chk("inv_ret_inh", {63'h0, bus.InHandler}, 64'h0);
    rd("inv_ret_state", 2'b11, 64'h0);

    // External IRQ then return
    bus.PC = 64'h40; bus.EStatus = 4'b0001; bus.ExtIRQ = 1'b1;
    tick();
    bus.EStatus = 4'b0000; bus.ExtIRQ = 1'b0;
    chk("irq_exc", {63'h0, bus.Exc}, 64'h1);
    chk("irq_ack", {63'h0, bus.ExtIAck}, 64'h1);
    tick();
    chk("irq_ack_off", {63'h0, bus.ExtIAck}, 64'h0);
    chk("irq_inh", {63'h0, bus.InHandler}, 64'h1);
    rd("irq_cnt", 2'b10, 64'h2);
    bus.ERet = 1'b1;
    #1;
    chk("irq_eretpc", bus.ERetPC, 64'h40);
    tick();
    bus.ERet = 1'b0;
    chk("irq_ret_inh", {63'h0, bus.InHandler}, 64'h0);

    // Masked IRQ inside a handler entered on a generic cause
    bus.PC = 64'h80; bus.EStatus = 4'b0101;
    tick();
    bus.EStatus = 4'b0000;
    tick();
    bus.PC = 64'h90; bus.EStatus = 4'b0001; bus.ExtIRQ = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("mask_exc", {63'h0, bus.Exc}, 64'h0);
      chk("mask_ack", {63'h0, bus.ExtIAck}, 64'h0);
      chk("mask_inh", {63'h0, bus.InHandler}, 64'h1);
    end
    rd("mask_elr", 2'b00, 64'h80);
    rd("mask_esr", 2'b01, 64'h5);
    rd("mask_cnt", 2'b10, 64'h3);
    bus.ERet = 1'b1;
    tick();
    bus.ERet = 1'b0;
    chk("mask_ret_inh", {63'h0, bus.InHandler}, 64'h0);
    chk("mask_ret_exc", {63'h0, bus.Exc}, 64'h0);
    rd("mask_ret_state", 2'b11, 64'h0);
    tick();
    chk("pend_exc", {63'h0, bus.Exc}, 64'h1);
    chk("pend_ack", {63'h0, bus.ExtIAck}, 64'h1);
    rd("pend_elr", 2'b00, 64'h90);
    rd("pend_cnt", 2'b10, 64'h4);
    bus.EStatus = 4'b0000; bus.ExtIRQ = 1'b0;
    tick();
    chk("pend_inh", {63'h0, bus.InHandler}, 64'h1);

    // Double fault
    bus.PC = 64'h200; bus.EStatus = 4'b0010;
    tick();
    bus.EStatus = 4'b0000;
    chk("df_halt", {63'h0, bus.Halt}, 64'h1);
    chk("df_exc", {63'h0, bus.Exc}, 64'h0);
    chk("df_inh", {63'h0, bus.InHandler}, 64'h0);
    chk("df_eretpc", bus.ERetPC, 64'h200);
    rd("df_elr", 2'b00, 64'h200);
    rd("df_esr", 2'b01, 64'h2);
    rd("df_cnt", 2'b10, 64'h5);
    rd("df_state", 2'b11, 64'h3);
    bus.ERet = 1'b1; bus.PC = 64'h999; bus.EStatus = 4'b0011;
    tick(); tick(); tick();
    bus.ERet = 1'b0; bus.EStatus = 4'b0000;
    chk("df_hold_halt", {63'h0, bus.Halt}, 64'h1);
    chk("df_hold_exc", {63'h0, bus.Exc}, 64'h0);
    rd("df_hold_elr", 2'b00, 64'h200);
    rd("df_hold_cnt", 2'b10, 64'h5);
    reset = 1'b0;
    tick();
    reset = 1'b1;
    chk("df_rst_halt", {63'h0, bus.Halt}, 64'h0);
    rd("df_rst_state", 2'b11, 64'h0);
    rd("df_rst_cnt", 2'b10, 64'h0);

    // Reset during TAKE
    bus.PC = 64'h10; bus.EStatus = 4'b0010;
    tick();
    bus.EStatus = 4'b0000;
    chk("rt_exc", {63'h0, bus.Exc}, 64'h1);
    reset = 1'b0;
    tick();
    reset = 1'b1;
    chk("rt_exc_off", {63'h0, bus.Exc}, 64'h0);
    rd("rt_state", 2'b11, 64'h0);
    rd("rt_elr", 2'b00, 64'h0);

    // Counter wrap on the narrow-counter instance
    rd_w("wrap_start", 2'b10, 64'h0);
    for (int i = 1; i <= 16; i++) begin
      bus_w.PC = 64'(i) << 4; bus_w.EStatus = 4'b0010;
      tick();
      bus_w.EStatus = 4'b0000;
      tick();
      bus_w.ERet = 1'b1;
      tick();
      bus_w.ERet = 1'b0;
      if (i == 15) rd_w("wrap_max", 2'b10, 64'hF);
    end
    rd_w("wrap_zero", 2'b10, 64'h0);
    rd_w("wrap_elr", 2'b00, 64'h100);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/exception_ctrl.md
# exception_ctrl

Exception and interrupt controller sitting directly downstream of the main decoder. Consumes the decoder's `EStatus`, `ERet` and the external `ExtIRQ` line, captures the faulting PC and cause into exception registers, and redirects fetch to the exception vector. Tracks handler entry and exit, masks nested interrupts, and halts on a fault taken inside a handler. Also serves the system-register read path used by MRS.

## Interface
- `VEC_BASE`, default 64'h0000_0000_0000_00D8: exception vector address; all causes share it.
- `clk`  in  1  system clock, all state updates on rising edge.
- `reset`  in  1  synchronous, active-low reset.
- `EStatus`  in  4  cause from decoder: 0000 none, 0001 external IRQ, 0010 invalid opcode, other nonzero generic.
- `ERet`  in  1  current instruction is ERET.
- `ExtIRQ`  in  1  level-sensitive external interrupt request.
- `PC`  in  64  address of the instruction currently executing.
- `SysRegSel`  in  2  system register select for MRS: 00 ELR, 01 ESR, 10 ExcCount, 11 state.
- `Exc`  out  1  one-cycle redirect: fetch loads `ExcVector`; core gates RegWrite/MemWrite this cycle.
- `ExcVector`  out  64  constant `VEC_BASE`.
- `ERetPC`  out  64  return address, always equal to ELR.
- `ExtIAck`  out  1  one-cycle acknowledge to interrupt source.
- `InHandler`  out  1  high while in HANDLER state.
- `Halt`  out  1  double fault; held until reset.
- `SysRegData`  out  64  combinational read of selected register, zero-extended.

## Operation
- Registers: ELR[63:0], ESR[3:0], ExcCount[15:0] (wraps 16'hFFFF -> 0), state[1:0].
- States: IDLE (00), TAKE (01), HANDLER (10), HALT (11).
- IDLE: if `EStatus` != 0 -> ELR <= `PC`, ESR <= `EStatus`, ExcCount++, go TAKE. `ERet` in IDLE: no state change (ERetPC still reflects ELR).
- TAKE: `Exc`=1; `ExtIAck`=1 only if ESR==0001. Inputs ignored. Unconditionally go HANDLER.
- HANDLER: `InHandler`=1. `ERet` -> IDLE. `EStatus`==0001 (IRQ) is masked: no capture, no ack, request remains pending at source. Any other nonzero `EStatus` -> HALT, ESR <= `EStatus`, ELR <= `PC`, ExcCount++.
- HALT: `Halt`=1, all other outputs frozen, only reset leaves.
- Priority in HANDLER: `ERet` over `EStatus`; a pending IRQ is taken from IDLE on the cycle after return if decoder still reports 0001.
- SysRegData 11 returns {62'b0, state}.

## Timing
- Reset (sampled low at edge): state IDLE, ELR=0, ESR=0, ExcCount=0; `Exc`, `ExtIAck`, `InHandler`, `Halt` = 0; `ERetPC`=0; `ExcVector`=VEC_BASE.
- Reset wins over every transition, including mid-TAKE and in HALT.
- Capture latency: cause in cycle N -> `Exc`/`ExtIAck` high in cycle N+1 exactly one cycle -> `InHandler` high from N+2.
- `ERet` in cycle M while HANDLER -> `InHandler` low from M+1; `ERetPC` valid combinationally in M.
- `SysRegData` and `ERetPC` are combinational from registers; updates visible the cycle after capture.
- All outputs except `SysRegData`, `ERetPC`, `ExcVector` are decoded from state/ESR only (no input-to-output paths).

## Test plan
- Reset: hold `reset`=0 two cycles with `EStatus`=0010 -> all outputs at reset values, ExcCount 0.
- Invalid opcode: IDLE, `PC`=0x100, `EStatus`=0010 one cycle -> next cycle `Exc`=1, `ExtIAck`=0; then `InHandler`=1; SysRegSel 00 reads 0x100, 01 reads 0x2, 10 reads 1.
- IRQ + return: `PC`=0x40, `EStatus`=0001 -> `Exc`=1 and `ExtIAck`=1 same cycle; in HANDLER assert `ERet` -> `ERetPC`=0x40, `InHandler` low next cycle.
- Masked IRQ: in HANDLER drive `EStatus`=0001 five cycles -> no `Exc`, no `ExtIAck`, ELR unchanged; after `ERet`, IRQ still present -> taken, `Exc` pulses.
- Double fault: in HANDLER, `PC`=0x200, `EStatus`=0010 -> `Halt`=1 permanently, ELR=0x200; `ERet` ignored; `reset`=0 -> IDLE, `Halt`=0.
- Counter wrap and reset mid-TAKE: take 65536 exceptions -> ExcCount reads 0; assert `reset`=0 in a TAKE cycle -> next cycle `Exc`=0, state IDLE.
